// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store,
// exposed through a registered read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] xx;
    acc = 8'h00;
    xx  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] acc;
    p   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state;
  logic [3:0]   r;
  logic [7:0]   rcon;
  logic [127:0] rk [0:NR];

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;

  // Outside EXPAND r can be 0 or 11; the guard keeps the read in range.
  always_comb begin
    prev_idx = r - 4'd1;
    prev     = (prev_idx <= LAST) ? rk[prev_idx] : '0;
  end

  assign {w0, w1, w2, w3} = prev;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .s (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      rk_data    <= '0;
      r          <= 4'd0;
      rcon       <= 8'h01;
      // NOTE: the store is reset entry by entry so stale key material never
      // survives a reset; this forces flops rather than a RAM macro.
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      // NOTE: non-blocking here means a read of the entry being written this
      // cycle returns its old contents.
      rk_data <= (rk_idx <= LAST) ? rk[rk_idx] : '0;
      if (key_load) begin
        rk[0]      <= key_in;
        r          <= 4'd1;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
        busy       <= 1'b1;
        state      <= EXPAND;
      end else begin
        case (state)
          EXPAND: begin
            rk[r] <= {n0, n1, n2, n3};
            rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            r     <= r + 4'd1;
            if (r == LAST) begin
              state      <= READY;
              busy       <= 1'b0;
              keys_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule sitting directly downstream of the AXI4-Lite key control register block. On a load strobe it captures the 128-bit key assembled from the four 32-bit key registers. It computes round keys 1–10 at one round per clock into an 11-entry round-key store. It then exposes that store through a registered read port to the AXI-Stream AES-128 cipher datapath.

## Interface
Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128. Round-key store depth is NR+1.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- key_in  in  128  cipher key. Bit mapping: key register 0 (offset 0x0) = key_in[127:96], register 1 (0x4) = [95:64], register 2 (0x8) = [63:32], register 3 (0xC) = [31:0]. Byte 0 of the AES key = key_in[127:120].
- key_load  in  1  single-cycle strobe; key_in is valid in the same cycle.
- busy  out  1  high while expansion is in progress.
- keys_valid  out  1  high when all 11 round keys are valid for the current key.
- rk_idx  in  4  round-key read index, 0..10.
- rk_data  out  128  registered round key for rk_idx.

## Operation
- FSM states: IDLE (after reset, no key), EXPAND, READY.
- Every state: on key_load, capture key_in into rk[0], set round counter r=1 and rcon=0x01, clear keys_valid, go to EXPAND. key_load has priority over all other activity, so a load during EXPAND restarts the expansion cleanly.
- EXPAND, each cycle:
  - compute rk[r] from rk[r-1].
  - words w0..w3 of rk[r-1], with w0 = bits [127:96].
  - t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - rk[r] = {n0,n1,n2,n3}.
  - rcon update: rcon = xtime(rcon), i.e. shift left by one, XOR 0x1b if bit 7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - r increments by 1.
  - when r==10 is written: go to READY, set keys_valid.
- SubWord uses four instances of the team's combinational aes_sbox (8-bit in, 8-bit out). RotWord rotates bytes left: {b1,b2,b3,b0}.
- READY: hold. The round-key store is static until the next key_load.
- Read port: rk_data <= rk[rk_idx] each cycle. If rk_idx > 10, rk_data <= 0. Reads are permitted in any state; data is meaningful only while keys_valid=1.
- No key_load while IDLE: keys_valid stays 0 indefinitely.

## Timing
- Reset values (asynchronous): state=IDLE, busy=0, keys_valid=0, rk_data=0, r=0, rcon=0x01, all rk entries=0.
- key_load sampled high at edge E0:
  - rk[0] written and busy=1 at E0.
  - rk[1]..rk[10] written at E1..E10.
  - at E10, busy=0 and keys_valid=1.
  - Expansion latency is 10 cycles, load to keys_valid.
- keys_valid falls at the same edge a new key_load is sampled.
- Read latency: rk_idx presented before edge Ek appears on rk_data after Ek (one cycle). A read of entry r in the cycle it is being written returns the old value.
- key_load in back-to-back cycles: the second strobe wins, and expansion completes 10 cycles after it.
- ARESET asserted mid-EXPAND: outputs clear immediately. After deassertion the block is in IDLE, and busy stays 0 until the next key_load.
- Critical path: one round (4 S-boxes plus an XOR chain of four) per cycle.

## Test plan
- FIPS-197 key: key_load with key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - keys_valid rises exactly 10 cycles after the strobe.
  - rk_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605.
  - rk_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - rk_idx=0 echoes the key.
- Zero key: rk[1]=62636363_62636363_62636363_62636363 and rk[10]=b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- Restart: zero key loaded, then the FIPS key loaded 4 cycles later.
  - keys_valid stays 0 until 10 cycles after the second strobe.
  - rk[10] equals the FIPS value.
- Reset mid-expansion: assert ARESET 5 cycles after key_load.
  - busy, keys_valid and rk_data are 0 immediately.
  - after release, no activity until a new key_load, whose expansion then completes correctly.
- Read port: sweep rk_idx 0..15 in READY.
  - one-cycle latency per index.
  - indices 11..15 return 0.
- Reload in READY: load the FIPS key, then the zero key.
  - keys_valid drops the cycle the strobe is sampled and rises 10 cycles later.
  - contents then match the zero-key schedule.
